axi_wr_arbiter: RTL

//  Two-master to one-slave AXI4 write-channel arbiter (AW/W/B), the write-side companion of the read crossbar.

---
 rtl/axi_wr_arbiter_if.sv | 42 ++++
 rtl/axi_wr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW/W/B) for one master/slave link.
// master drives AW/W payloads and bready; slave drives the readies, bvalid and B payload.
interface axi_wr_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [ID_W-1:0]       awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [ID_W-1:0]       bid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-master AXI4 write arbiter (AW/W/B), round-robin grant held from request to B handshake.
// Latency: AW reaches the slave one cycle after a request in IDLE; W and B are combinational.
// Backpressure: slave ready/valid routed to the granted master only; the other sees ready=valid=0.
module axi_wr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    axi_wr_arbiter_if.slave  m0,
    axi_wr_arbiter_if.slave  m1,
    axi_wr_arbiter_if.master s,
    output logic             wlast_err
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;

    logic              sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic [ADDR_W-1:0] sel_awaddr;
    logic [ID_W-1:0]   sel_awid;
    logic [7:0]        sel_awlen;
    logic [2:0]        sel_awsize;
    logic [1:0]        sel_awburst;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              aw_fire, w_fire, b_fire, last_beat;

    assign sel_awvalid = grant_q ? m1.awvalid : m0.awvalid;
    assign sel_awaddr  = grant_q ? m1.awaddr  : m0.awaddr;
    assign sel_awid    = grant_q ? m1.awid    : m0.awid;
    assign sel_awlen   = grant_q ? m1.awlen   : m0.awlen;
    assign sel_awsize  = grant_q ? m1.awsize  : m0.awsize;
    assign sel_awburst = grant_q ? m1.awburst : m0.awburst;
    assign sel_wvalid  = grant_q ? m1.wvalid  : m0.wvalid;
    assign sel_wdata   = grant_q ? m1.wdata   : m0.wdata;
    assign sel_wstrb   = grant_q ? m1.wstrb   : m0.wstrb;
    assign sel_wlast   = grant_q ? m1.wlast   : m0.wlast;
    assign sel_bready  = grant_q ? m1.bready  : m0.bready;

    assign last_beat = (beat_cnt_q == len_q);

    assign s.awvalid = (state_q == ADDR) && sel_awvalid;
    assign s.awaddr  = sel_awaddr;
    assign s.awid    = sel_awid;
    assign s.awlen   = sel_awlen;
    assign s.awsize  = sel_awsize;
    assign s.awburst = sel_awburst;
    assign s.wvalid  = (state_q == DATA) && sel_wvalid;
    assign s.wdata   = sel_wdata;
    assign s.wstrb   = sel_wstrb;
    // The slave always sees the beat-count last, never the master's flag.
    assign s.wlast   = (state_q == DATA) && last_beat;
    assign s.bready  = (state_q == RESP) && sel_bready;

    assign aw_fire = s.awvalid && s.awready;
    assign w_fire  = s.wvalid && s.wready;
    assign b_fire  = s.bvalid && s.bready;

    assign m0.awready = (state_q == ADDR) && !grant_q && s.awready;
    assign m1.awready = (state_q == ADDR) &&  grant_q && s.awready;
    assign m0.wready  = (state_q == DATA) && !grant_q && s.wready;
    assign m1.wready  = (state_q == DATA) &&  grant_q && s.wready;
    assign m0.bvalid  = (state_q == RESP) && !grant_q && s.bvalid;
    assign m1.bvalid  = (state_q == RESP) &&  grant_q && s.bvalid;
    assign m0.bresp   = s.bresp;
    assign m1.bresp   = s.bresp;
    assign m0.bid     = s.bid;
    assign m1.bid     = s.bid;

    assign wlast_err = w_fire && (sel_wlast != last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
            len_q      <= 8'd0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (m0.awvalid || m1.awvalid) begin
                    grant_d = (m0.awvalid && m1.awvalid) ? rr_ptr_q : m1.awvalid;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (aw_fire) begin
                    len_d      = sel_awlen;
                    beat_cnt_d = 8'd0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (w_fire) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last_beat) state_d = RESP;
                end
            end
            RESP: begin
                if (b_fire) begin
                    rr_ptr_d = ~grant_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
